// File: rtl/hilihase_pkg.sv
// hilihase_pkg: shared 4-state drive codes, drive error causes and command record.
package hilihase_pkg;
    localparam int HL_ID_W = 8;
    localparam int HL_TIME_W = 32;
    typedef enum logic [1:0] {HL_0 = 2'd0, HL_1 = 2'd1, HL_X = 2'd2, HL_Z = 2'd3} hl_code_t;
    typedef enum logic [1:0] {NONE = 2'd0, BAD_ID = 2'd1, BAD_VAL = 2'd2, LATE = 2'd3} hl_drv_err_t;
    // `time` is a keyword, so the apply slot is carried in `slot`.
    typedef struct packed {
        logic [HL_TIME_W-1:0] slot;
        logic [HL_ID_W-1:0]   id;
        logic [7:0]           val;
    } hl_drv_cmd_t;
endpackage

// File: rtl/hilihase_cmd_fifo.sv
// hilihase_cmd_fifo: synchronous FIFO with clear, head always visible on dout.
module hilihase_cmd_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= din;
    assign dout = mem[rp[AW-1:0]];
    assign count = wp - rp;
    assign empty = wp == rp;
    assign full = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/hilihase_drive_player.sv
// hilihase_drive_player: ordered, time-slot-accurate player of queued drive commands.
// Define HILIHASE_DRV_LATE_ERR_EN to drop commands whose slot has already passed.
module hilihase_drive_player
    import hilihase_pkg::*;
#(
    parameter int NUM_SIGS = 8,
    parameter int ID_W = HL_ID_W,
    parameter int TIME_W = HL_TIME_W,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic                    flush,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ID_W-1:0]         cmd_id,
    input  logic [7:0]              cmd_val,
    input  logic [TIME_W-1:0]       cmd_time,
    output logic [TIME_W-1:0]       cur_time,
    output logic [2*NUM_SIGS-1:0]   drv_code,
    output logic [NUM_SIGS-1:0]     drv_strobe,
    output logic                    q_empty,
    output logic                    err_pulse,
    output logic [1:0]              err_code
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, FLUSH = 2'd2;
    typedef struct packed {
        logic [TIME_W-1:0] slot;
        logic [ID_W-1:0]   id;
        logic [7:0]        val;
    } cmd_t;
    cmd_t head, din;
    logic [1:0] state;
    logic [$clog2(DEPTH):0] count;
    logic [TIME_W-1:0] age;
    logic [NUM_SIGS-1:0] hit;
    logic [1:0] code;
    logic full, push, pop, due, late, id_ok, bad_val;
    assign din = '{slot: cmd_time, id: cmd_id, val: cmd_val};
    assign cmd_ready = !rst && !full && state != FLUSH && !flush;
    assign push = cmd_valid && cmd_ready;
    // Serial-number comparison keeps "due" correct across counter wrap.
    assign age = cur_time - head.slot;
    assign due = !q_empty && !age[TIME_W-1];
    assign pop = state == ARMED && due && !flush;
    assign id_ok = head.id != '0 && head.id <= ID_W'(NUM_SIGS);
    assign bad_val = head.val > 8'd3;
    assign code = bad_val ? 2'(HL_X) : head.val[1:0];
`ifdef HILIHASE_DRV_LATE_ERR_EN
    assign late = age != '0;
`else
    assign late = 1'b0;
`endif
    assign hit = (pop && id_ok && !late) ? NUM_SIGS'(1) << (head.id - 1'b1) : '0;
    hilihase_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clear(flush),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(head),
        .full(full),
        .empty(q_empty),
        .count(count)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else if (flush) state <= FLUSH;
        else state <= state == FLUSH ? IDLE
                    : state == IDLE ? (push ? ARMED : IDLE)
                    : (pop && !push && count == ($clog2(DEPTH)+1)'(1)) ? IDLE : ARMED;
    always_ff @(posedge clk or posedge rst)
        if (rst) cur_time <= '0;
        else if (step) cur_time <= cur_time + 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            drv_code <= {NUM_SIGS{2'(HL_Z)}};
            drv_strobe <= '0;
            err_pulse <= 1'b0;
            err_code <= NONE;
        end else begin
            drv_strobe <= hit;
            err_pulse <= pop && (!id_ok || late || bad_val);
            for (int k = 0; k < NUM_SIGS; k++)
                if (hit[k]) drv_code[2*k +: 2] <= code;
            if (pop && !id_ok) err_code <= BAD_ID;
            else if (pop && late) err_code <= LATE;
            else if (pop && bad_val) err_code <= BAD_VAL;
        end
endmodule
